// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: ROM request/response, decoder handshake and PC control.
//   master : fetch unit side (drives o_* signals)
//   slave  : environment side (ROM + decoder, drives i_* signals)
interface fetch_unit_if;
  logic        i_Run;
  logic [14:0] o_Rom_Addr;
  logic        o_Rom_Req;
  logic        i_Rom_Ack;
  logic [15:0] i_Rom_Data;
  logic [15:0] o_Instruction;
  logic        o_Instr_Valid;
  logic        i_Instr_Ready;
  logic        i_PC_Load;
  logic        i_PC_Inc;
  logic [14:0] i_Jump_Target;
  logic [14:0] o_PC;
  logic        o_Halted;

  modport master (
    input  i_Run, i_Rom_Ack, i_Rom_Data, i_Instr_Ready,
           i_PC_Load, i_PC_Inc, i_Jump_Target,
    output o_Rom_Addr, o_Rom_Req, o_Instruction, o_Instr_Valid,
           o_PC, o_Halted
  );

  modport slave (
    output i_Run, i_Rom_Ack, i_Rom_Data, i_Instr_Ready,
           i_PC_Load, i_PC_Inc, i_Jump_Target,
    input  o_Rom_Addr, o_Rom_Req, o_Instruction, o_Instr_Valid,
           o_PC, o_Halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches 16-bit words from ROM at PC, holds the
// instruction for the decoder until consumed, then advances / jumps / refetches.
// Optional halt-loop detection under macro FETCH_HALT_DETECT_EN: a consumed
// self-jump parks the unit in HALT with o_Halted=1 until reset.
// Ports:
//   i_Clk   : system clock, rising edge
//   i_Rst_n : asynchronous active-low reset
//   bus     : fetch_unit_if.master (ROM port, decoder handshake, PC control)
module fetch_unit (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
`ifdef FETCH_HALT_DETECT_EN
    ,HALT = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [14:0] pc;
  logic [15:0] instr;
  logic        instr_vld;
  logic        rom_req;
  logic        consume;
  logic [14:0] pc_next;
  logic        self_jump;

  // Decoder controls only matter on the consume cycle.
  assign consume   = (state == HOLD) && bus.i_Instr_Ready;
  assign self_jump = bus.i_PC_Load && (bus.i_Jump_Target == pc);

  always_comb begin
    pc_next = pc;
    if (bus.i_PC_Load)     pc_next = bus.i_Jump_Target;
    else if (bus.i_PC_Inc) pc_next = pc + 15'd1;   // 15-bit wrap is natural
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halted;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      instr_vld <= 1'b0;
      rom_req   <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      halted    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Run) begin
            state   <= FETCH;
            rom_req <= 1'b1;
          end
        end
        FETCH: begin
          // i_Run is not looked at here: an issued request always completes.
          if (bus.i_Rom_Ack) begin
            instr     <= bus.i_Rom_Data;
            instr_vld <= 1'b1;
            rom_req   <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            instr_vld <= 1'b0;
            pc        <= pc_next;
`ifdef FETCH_HALT_DETECT_EN
            if (self_jump) begin
              state  <= HALT;
              halted <= 1'b1;
            end else
`endif
            if (bus.i_Run) begin
              state   <= FETCH;
              rom_req <= 1'b1;
            end else begin
              state   <= IDLE;
            end
          end
        end
`ifdef FETCH_HALT_DETECT_EN
        HALT: begin
          state <= HALT;
        end
`endif
        default: begin
          state     <= IDLE;
          instr_vld <= 1'b0;
          rom_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_PC          = pc;
  assign bus.o_Rom_Addr    = pc;
  assign bus.o_Rom_Req     = rom_req;
  assign bus.o_Instruction = instr;
  assign bus.o_Instr_Valid = instr_vld;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.o_Halted      = halted;
`else
  assign bus.o_Halted      = 1'b0;
  logic unused_self_jump;
  assign unused_self_jump  = self_jump;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_unit_if bus ();
  fetch_unit dut (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_Rom_Ack     = 1'b0;
    bus.i_Rom_Data    = 16'h0;
    bus.i_Instr_Ready = 1'b0;
    bus.i_PC_Load     = 1'b0;
    bus.i_PC_Inc      = 1'b0;
    bus.i_Jump_Target = 15'h0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {15'h0, bus.o_Rom_Req}, 16'h0);
    chk("rst_pc", {1'b0, bus.o_PC}, 16'h0);
    chk("rst_vld", {15'h0, bus.o_Instr_Valid}, 16'h0);
    tick();
    rst_n = 1'b1;
  endtask

  // In FETCH: ack with data, expect HOLD with data next cycle.
  task automatic ack_with(input logic [15:0] d);
    bus.i_Rom_Ack  = 1'b1;
    bus.i_Rom_Data = d;
    tick();
    bus.i_Rom_Ack  = 1'b0;
    chk("ack_vld", {15'h0, bus.o_Instr_Valid}, 16'h1);
    chk("ack_instr", bus.o_Instruction, d);
    chk("ack_req_low", {15'h0, bus.o_Rom_Req}, 16'h0);
  endtask

  task automatic consume(input logic ld, input logic inc, input logic [14:0] tgt);
    bus.i_Instr_Ready = 1'b1;
    bus.i_PC_Load     = ld;
    bus.i_PC_Inc      = inc;
    bus.i_Jump_Target = tgt;
    tick();
    bus.i_Instr_Ready = 1'b0;
    bus.i_PC_Load     = 1'b0;
    bus.i_PC_Inc      = 1'b0;
    bus.i_Jump_Target = 15'h0;
    chk("cons_vld_low", {15'h0, bus.o_Instr_Valid}, 16'h0);
  endtask

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return {a, 1'b1} ^ 16'hA5C3;
  endfunction

  initial begin
    logic [14:0] exp_pc;
    logic [15:0] d;
    logic        ld, inc;
    logic [14:0] tgt;
    int          dly;

    rst_n = 1'b0;
    bus.i_Run = 1'b0;
    idle_inputs();
    #2;
    chk("reset_pc", {1'b0, bus.o_PC}, 16'h0);
    chk("reset_instr", bus.o_Instruction, 16'h0);
    chk("reset_vld", {15'h0, bus.o_Instr_Valid}, 16'h0);
    chk("reset_req", {15'h0, bus.o_Rom_Req}, 16'h0);
    chk("reset_halted", {15'h0, bus.o_Halted}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_req", {15'h0, bus.o_Rom_Req}, 16'h0);

    // First fetch, ack in the first FETCH cycle.
    bus.i_Run = 1'b1;
    bus.i_Rom_Ack = 1'b1;
    bus.i_Rom_Data = 16'h007B;
    tick();
    chk("f1_req", {15'h0, bus.o_Rom_Req}, 16'h1);
    chk("f1_addr", {1'b0, bus.o_Rom_Addr}, 16'h0);
    chk("f1_vld", {15'h0, bus.o_Instr_Valid}, 16'h0);
    tick();
    bus.i_Rom_Ack = 1'b0;
    chk("f1_vld2", {15'h0, bus.o_Instr_Valid}, 16'h1);
    chk("f1_instr", bus.o_Instruction, 16'h007B);

    // Decoder stalls 5 cycles; instruction must stay stable.
    for (int i = 0; i < 5; i++) begin
      bus.i_Rom_Ack = 1'b1;  // ignored outside FETCH
      bus.i_Rom_Data = 16'hFFFF;
      tick();
      chk("stall_vld", {15'h0, bus.o_Instr_Valid}, 16'h1);
      chk("stall_instr", bus.o_Instruction, 16'h007B);
    end
    bus.i_Rom_Ack = 1'b0;
    consume(1'b0, 1'b1, 15'h0);
    chk("inc_pc", {1'b0, bus.o_PC}, 16'h1);

    // Ack delayed 3 cycles: request high 4 cycles, address stable.
    for (int i = 0; i < 4; i++) begin
      chk("dly_req", {15'h0, bus.o_Rom_Req}, 16'h1);
      chk("dly_addr", {1'b0, bus.o_Rom_Addr}, 16'h1);
      if (i < 3) tick();
    end
    ack_with(16'hBEEF);

    // Wrap and priority.
    consume(1'b1, 1'b0, 15'h7FFF);
    chk("ld_pc", {1'b0, bus.o_PC}, 16'h7FFF);
    ack_with(16'h1234);
    consume(1'b0, 1'b1, 15'h0);
    chk("wrap_pc", {1'b0, bus.o_PC}, 16'h0000);
    ack_with(16'h4321);
    consume(1'b1, 1'b1, 15'h0010);
    chk("prio_pc", {1'b0, bus.o_PC}, 16'h0010);
    ack_with(16'h5555);

    // Self-jump at 0x0020.
    consume(1'b1, 1'b0, 15'h0020);
    ack_with(16'h6666);
    consume(1'b1, 1'b0, 15'h0020);
    chk("sj_pc", {1'b0, bus.o_PC}, 16'h0020);
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 3; i++) begin
      bus.i_Rom_Ack = 1'b1;
      chk("halt_flag", {15'h0, bus.o_Halted}, 16'h1);
      chk("halt_req", {15'h0, bus.o_Rom_Req}, 16'h0);
      chk("halt_vld", {15'h0, bus.o_Instr_Valid}, 16'h0);
      chk("halt_pc", {1'b0, bus.o_PC}, 16'h0020);
      tick();
    end
    bus.i_Rom_Ack = 1'b0;
`else
    chk("sj_halted", {15'h0, bus.o_Halted}, 16'h0);
    chk("sj_req", {15'h0, bus.o_Rom_Req}, 16'h1);
    chk("sj_addr", {1'b0, bus.o_Rom_Addr}, 16'h0020);
    ack_with(16'h7777);
    chk("sj_halted2", {15'h0, bus.o_Halted}, 16'h0);
`endif

    // Reset during FETCH at PC=5, late ack ignored.
    bus.i_Run = 1'b0;
    do_reset();
    bus.i_Run = 1'b1;
    tick();
    ack_with(16'h0A0A);
    consume(1'b1, 1'b0, 15'h0005);
    chk("r5_pc", {1'b0, bus.o_PC}, 16'h0005);
    chk("r5_req", {15'h0, bus.o_Rom_Req}, 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {15'h0, bus.o_Rom_Req}, 16'h0);
    chk("arst_pc", {1'b0, bus.o_PC}, 16'h0);
    bus.i_Run = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_Rom_Ack = 1'b1;
    bus.i_Rom_Data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_ack_vld", {15'h0, bus.o_Instr_Valid}, 16'h0);
      chk("late_ack_req", {15'h0, bus.o_Rom_Req}, 16'h0);
    end
    bus.i_Rom_Ack = 1'b0;

    // Run dropped during an outstanding request.
    bus.i_Run = 1'b1;
    tick();
    bus.i_Run = 1'b0;
    tick();
    chk("drop_req", {15'h0, bus.o_Rom_Req}, 16'h1);
    ack_with(16'hC0DE);
    consume(1'b0, 1'b1, 15'h0);
    chk("drop_idle_req", {15'h0, bus.o_Rom_Req}, 16'h0);
    tick();
    tick();
    chk("drop_idle_req2", {15'h0, bus.o_Rom_Req}, 16'h0);
    chk("drop_pc", {1'b0, bus.o_PC}, 16'h1);

    // Randomized: model tracks the program counter from the PC rules only.
    do_reset();
    bus.i_Run = 1'b1;
    tick();
    exp_pc = 15'h0;
    for (int n = 0; n < 200; n++) begin
      dly = $urandom_range(0, 3);
      for (int i = 0; i <= dly; i++) begin
        chk("rnd_req", {15'h0, bus.o_Rom_Req}, 16'h1);
        chk("rnd_addr", {1'b0, bus.o_Rom_Addr}, {1'b0, exp_pc});
        chk("rnd_vld_f", {15'h0, bus.o_Instr_Valid}, 16'h0);
        if (i < dly) tick();
      end
      d = rom_word(exp_pc);
      ack_with(d);
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) begin
        bus.i_PC_Load = $urandom_range(0, 1);
        bus.i_Jump_Target = 15'($urandom);
        tick();
        chk("rnd_hold", bus.o_Instruction, d);
        chk("rnd_hold_pc", {1'b0, bus.o_PC}, {1'b0, exp_pc});
      end
      ld  = ($urandom_range(0, 3) == 0);
      inc = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       tgt = 15'h7FFF;
        1:       tgt = exp_pc;
        default: tgt = 15'($urandom);
      endcase
`ifdef FETCH_HALT_DETECT_EN
      if (ld && tgt == exp_pc) tgt = exp_pc + 15'd3;
`endif
      if (exp_pc == 15'h7FFF && $urandom_range(0, 1) == 1) begin
        ld = 1'b0;
        inc = 1'b1;
      end
      consume(ld, inc, tgt);
      if (ld)       exp_pc = tgt;
      else if (inc) exp_pc = 15'((32'(exp_pc) + 1) % 32768);
      chk("rnd_pc", {1'b0, bus.o_PC}, {1'b0, exp_pc});
      if (n % 37 == 5) exp_pc = exp_pc;  // keep model purely rule-driven
      if (n % 50 == 49) begin
        bus.i_PC_Load = 1'b1;
        bus.i_Jump_Target = 15'h7FFF;
        d = rom_word(exp_pc);
        ack_with(d);
        consume(1'b1, 1'b0, 15'h7FFF);
        exp_pc = 15'h7FFF;
        chk("rnd_jump_max", {1'b0, bus.o_PC}, 16'h7FFF);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port i_Clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port i_Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_Run, input, 1, fetch enable; 0 stops new ROM requests.
REQ-004 SHALL have port o_Rom_Addr, output, 15, ROM word address, equal to o_PC.
REQ-005 SHALL have port o_Rom_Req, output, 1, ROM read request.
REQ-006 SHALL have port i_Rom_Ack, input, 1, ROM read data valid this cycle.
REQ-007 SHALL have port i_Rom_Data, input, 16, ROM read data.
REQ-008 SHALL have port o_Instruction, output, 16, held instruction for the decoder.
REQ-009 SHALL have port o_Instr_Valid, output, 1, o_Instruction valid.
REQ-010 SHALL have port i_Instr_Ready, input, 1, execute stage consumes the instruction this cycle.
REQ-011 SHALL have port i_PC_Load, input, 1, decoder jump-taken.
REQ-012 SHALL have port i_PC_Inc, input, 1, decoder sequential advance.
REQ-013 SHALL have port i_Jump_Target, input, 15, A-register value used as the jump address.
REQ-014 SHALL have port o_PC, output, 15, address of the instruction being fetched or held.
REQ-015 SHALL have port o_Halted, output, 1, halt-loop detected (REQ-030).

Function
REQ-016 SHALL implement the states IDLE, FETCH, HOLD and HALT.
REQ-017 IDLE SHALL go to FETCH on the first clock with i_Run=1; o_Rom_Req=0.
REQ-018 FETCH SHALL drive o_Rom_Req=1 and o_Rom_Addr=o_PC until the cycle of i_Rom_Ack=1, inclusive.
REQ-019 In FETCH, i_Rom_Ack=1 SHALL latch i_Rom_Data into o_Instruction and move to HOLD; o_Instr_Valid=1 from the next cycle, so latency is 1 cycle after ack.
REQ-020 An ack in the first FETCH cycle SHALL be legal; sustained throughput SHALL be one instruction per 2 cycles.
REQ-021 i_Rom_Ack SHALL be ignored outside FETCH.
REQ-022 In FETCH, i_Run=0 SHALL NOT abort an outstanding request; the request completes to HOLD.
REQ-023 In HOLD, o_Instr_Valid=1 and o_Instruction SHALL stay stable until a cycle with i_Instr_Ready=1.
REQ-024 On consume, the next PC SHALL be i_Jump_Target if i_PC_Load=1, else o_PC+1 if i_PC_Inc=1, else o_PC unchanged (refetch).
REQ-025 i_PC_Load SHALL take priority when i_PC_Load and i_PC_Inc are both 1.
REQ-026 o_PC+1 SHALL wrap 0x7FFF to 0x0000 (15-bit modular).
REQ-027 On consume, the FSM SHALL go to FETCH if i_Run=1, else to IDLE; o_Instr_Valid=0 the cycle after consume.
REQ-028 i_PC_Load, i_PC_Inc and i_Jump_Target SHALL be sampled only in a HOLD cycle with i_Instr_Ready=1.

Reset
REQ-029 While i_Rst_n=0, outputs SHALL be: state=IDLE, o_PC=0, o_Instruction=0, o_Instr_Valid=0, o_Rom_Req=0, o_Halted=0, independent of i_Clk; reset mid-request SHALL drop the request, and a late ack after release SHALL be ignored (IDLE).

Configuration
REQ-030 With macro FETCH_HALT_DETECT_EN defined: a consume with i_PC_Load=1 and i_Jump_Target==o_PC SHALL enter HALT, set o_Halted=1, o_Rom_Req=0 and o_Instr_Valid=0 until reset; o_PC keeps that address.
REQ-031 Without FETCH_HALT_DETECT_EN: no HALT state, o_Halted tied 0, and a self-jump SHALL refetch normally per REQ-024.

Verification
REQ-032 Reset then i_Run=1, ROM acks in 1st FETCH cycle with 0x007B -> o_Rom_Addr=0, o_Instr_Valid=1 with o_Instruction=0x007B two cycles after the i_Run edge.
REQ-033 ROM ack delayed 3 cycles -> o_Rom_Req held high 4 cycles with stable address; i_Instr_Ready held 0 for 5 cycles -> o_Instruction stable; consume with i_PC_Inc=1 -> next o_PC=1.
REQ-034 o_PC=0x7FFF, consume with i_PC_Inc=1 -> o_PC=0x0000; consume with i_PC_Load=1, i_PC_Inc=1, i_Jump_Target=0x0010 -> o_PC=0x0010.
REQ-035 i_Rst_n pulled low during FETCH at o_PC=5 -> o_Rom_Req=0 and o_PC=0 immediately; ack asserted after release -> ignored, o_Instr_Valid stays 0.
REQ-036 Macro defined: at o_PC=0x0020 consume with i_PC_Load=1, i_Jump_Target=0x0020 -> o_Halted=1, no further o_Rom_Req; macro undefined -> refetch of 0x0020, o_Halted=0.
REQ-037 i_Run dropped during an outstanding request -> ack completes to HOLD; after consume the FSM goes IDLE with o_Rom_Req=0.
